siso_rr_serializer: RTL and testbench

Round-robin arbiter and sequencer that shares one LSB-first serial output shift path between two parallel-word requesters. A granted word is captured, shifted out over N cycles with valid/framing flags, then the path is released. It sits in front of any serial consumer that expects a single N-bit LSB-first stream, such as a SISO chain or serial link.

---
 rtl/siso_rr_serializer.sv | 116 +++++++++++
 tb/tb_siso_rr_serializer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_rr_serializer.sv
// Round-robin share of one LSB-first serial shift path between two word requesters.
// Bit 0 appears the cycle after acceptance; requesters see ready only while the path is idle.
module siso_rr_serializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] data0,
    output logic         ready0,
    input  logic         req1,
    input  logic [N-1:0] data1,
    output logic         ready1,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         frame_start,
    output logic         frame_end,
    output logic         owner,
    output logic         busy
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [N-1:0]   shift_reg;
    logic [N-1:0]   win_data;
    logic [CW-1:0]  count;
    logic           last;
    logic           accept;
    logic           winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ties go to the requester that was not served last.
    always_comb begin
        next_state = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        accept     = 1'b0;
        winner     = 1'b0;
        win_data   = data0;
        case (state)
            IDLE: begin
                if (!rst && (req0 || req1)) begin
                    accept     = 1'b1;
                    winner     = (req0 && req1) ? ~last : req1;
                    ready0     = ~winner;
                    ready1     = winner;
                    win_data   = winner ? data1 : data0;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (count == LAST_CNT) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit 0 goes straight to the output register at acceptance, so the
    // shift register only holds the bits still to come.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg    <= '0;
            count        <= '0;
            last         <= 1'b1;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            owner        <= 1'b0;
            busy         <= 1'b0;
        end else if (accept) begin
            shift_reg    <= win_data >> 1;
            count        <= '0;
            last         <= winner;
            owner        <= winner;
            serial_out   <= win_data[0];
            serial_valid <= 1'b1;
            busy         <= 1'b1;
            frame_start  <= 1'b1;
            frame_end    <= 1'b0;
        end else if (state == SHIFT) begin
            frame_start <= 1'b0;
            if (count == LAST_CNT) begin
                shift_reg    <= '0;
                count        <= '0;
                serial_out   <= 1'b0;
                serial_valid <= 1'b0;
                busy         <= 1'b0;
                frame_end    <= 1'b0;
            end else begin
                count      <= count + CW'(1);
                serial_out <= shift_reg[0];
                shift_reg  <= shift_reg >> 1;
                frame_end  <= ((count + CW'(1)) == LAST_CNT);
            end
        end
    end

endmodule

// File: tb/tb_siso_rr_serializer.sv
// Randomized and directed stimulus against a cycle-counting reference model of the serializer.
module tb_siso_rr_serializer;

    localparam int N  = 4;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0]  data0 = '0, data1 = '0;
    logic          ready0, ready1, serial_out, serial_valid, frame_start, frame_end, owner, busy;

    logic          req0_b = 1'b0, req1_b = 1'b0;
    logic [NB-1:0] data0_b = '0, data1_b = '0;
    logic          ready0_b, ready1_b, serial_out_b, serial_valid_b, frame_start_b, frame_end_b, owner_b, busy_b;

    always #5 clk = ~clk;

    siso_rr_serializer #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ready0(ready0),
        .req1(req1), .data1(data1), .ready1(ready1),
        .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .frame_end(frame_end),
        .owner(owner), .busy(busy)
    );

    siso_rr_serializer #(.N(NB)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0_b), .data0(data0_b), .ready0(ready0_b),
        .req1(req1_b), .data1(data1_b), .ready1(ready1_b),
        .serial_out(serial_out_b), .serial_valid(serial_valid_b),
        .frame_start(frame_start_b), .frame_end(frame_end_b),
        .owner(owner_b), .busy(busy_b)
    );

    typedef struct packed {
        logic b;
        logic s;
        logic e;
        logic o;
    } exp_t;

    exp_t sbq[$];
    int   g_cyc[$];
    logic g_own[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   next_free = 0;
    logic last = 1'b1;
    logic p0 = 1'b0, p1 = 1'b0;
    logic prev_end = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive pending requests, check the grant the
    // model predicts, and queue the frame bits the model expects.
    task automatic tick();
        logic         w_any;
        logic         w;
        logic [N-1:0] word;
        req0 = p0;
        req1 = p1;
        #1;
        w_any = (cyc >= next_free) && (p0 || p1);
        w     = (p0 && p1) ? ~last : p1;
        check_bit("ready0", ready0, w_any && !w);
        check_bit("ready1", ready1, w_any && w);
        if (ready0 || ready1) begin
            g_cyc.push_back(cyc);
            g_own.push_back(ready1);
        end
        if (w_any) begin
            word = w ? data1 : data0;
            for (int k = 0; k < N; k++)
                sbq.push_back('{b: word[k], s: (k == 0), e: (k == N - 1), o: w});
            last      = w;
            next_free = cyc + N + 1;
            if (w) p1 = 1'b0;
            else   p0 = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        sbq.delete();
        last      = 1'b1;
        next_free = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_ready0"}, ready0, 1'b0);
        check_bit({tag, "_ready1"}, ready1, 1'b0);
        check_bit({tag, "_serial_out"}, serial_out, 1'b0);
        check_bit({tag, "_serial_valid"}, serial_valid, 1'b0);
        check_bit({tag, "_frame_start"}, frame_start, 1'b0);
        check_bit({tag, "_frame_end"}, frame_end, 1'b0);
        check_bit({tag, "_owner"}, owner, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic serve(input string name);
        for (int i = 0; i < 40 && (p0 || p1); i++) tick();
        check_bit({name, "_served"}, p0 | p1, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        p0 = 1'b0;
        p1 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_end = 1'b0;
            end else begin
                if (serial_valid) begin
                    check_bit("busy_in_frame", busy, 1'b1);
                    if (prev_end) begin
                        checks++;
                        failures++;
                        $display("FAIL back_to_back frame at t=%0t", $time);
                    end
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bit serial_out=%b with nothing expected (t=%0t)", serial_out, $time);
                    end else begin
                        e = sbq.pop_front();
                        check_bit("serial_out", serial_out, e.b);
                        check_bit("frame_start", frame_start, e.s);
                        check_bit("frame_end", frame_end, e.e);
                        check_bit("owner", owner, e.o);
                    end
                end else begin
                    check_bit("busy_idle", busy, 1'b0);
                end
                prev_end = serial_valid && frame_end;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [NB-1:0] w8;
        // Reset state, with both requests raised to prove ready is held low.
        req0 = 1'b1;
        req1 = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single request, 4'b1011 -> bits 1,1,0,1, one ready cycle.
        g_cyc.delete(); g_own.delete();
        data0 = 4'b1011;
        p0 = 1'b1;
        serve("single");
        idle_cycles(N + 2);
        check_int("single_grants", g_own.size(), 1);

        // Tie after reset: requester 0 first, then 1 after one idle cycle.
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        g_cyc.delete(); g_own.delete();
        data0 = 4'hA;
        data1 = 4'h5;
        p0 = 1'b1;
        p1 = 1'b1;
        serve("tie");
        check_int("tie_grants", g_own.size(), 2);
        if (g_own.size() == 2) begin
            check_bit("tie_first", g_own[0], 1'b0);
            check_bit("tie_second", g_own[1], 1'b1);
            check_int("tie_spacing", g_cyc[1] - g_cyc[0], N + 1);
        end
        idle_cycles(N + 2);

        // Both held for 20 cycles: strict alternation, N+1 apart.
        g_cyc.delete(); g_own.delete();
        for (int i = 0; i < 20; i++) begin
            p0 = 1'b1;
            p1 = 1'b1;
            data0 = N'($urandom);
            data1 = N'($urandom);
            tick();
        end
        check_int("alt_grants", g_own.size(), 4);
        for (int i = 1; i < g_own.size(); i++) begin
            check_bit("alt_owner", g_own[i], i[0]);
            check_int("alt_spacing", g_cyc[i] - g_cyc[i-1], N + 1);
        end
        idle_cycles(N + 2);

        // Late req1 and mid-frame data0 changes.
        g_cyc.delete(); g_own.delete();
        data0 = 4'h6;
        p0 = 1'b1;
        serve("late_first");
        p1 = 1'b1;
        data1 = 4'h9;
        for (int i = 0; i < 2 * N; i++) begin
            data0 = N'($urandom);
            tick();
        end
        check_int("late_grants", g_own.size(), 2);
        if (g_own.size() == 2) begin
            check_bit("late_second_owner", g_own[1], 1'b1);
            check_int("late_gap", g_cyc[1] - g_cyc[0], N + 1);
        end
        idle_cycles(N + 2);

        // Asynchronous reset while bit 2 is on the line.
        data0 = 4'hC;
        p0 = 1'b1;
        serve("abort");
        tick();
        @(posedge clk);
        #2;
        req0 = 1'b1;
        req1 = 1'b1;
        rst  = 1'b1;
        model_reset();
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        g_cyc.delete(); g_own.delete();
        idle_cycles(2);
        p0 = 1'b1;
        p1 = 1'b1;
        serve("post_rst");
        if (g_own.size() >= 1) check_bit("post_rst_winner", g_own[0], 1'b0);
        else check_int("post_rst_grants", g_own.size(), 2);
        idle_cycles(N + 2);

        // Random traffic; data wanders every cycle, the model keeps the accepted word.
        for (int i = 0; i < 400; i++) begin
            if (!p0 && ($urandom_range(0, 3) == 0)) p0 = 1'b1;
            if (!p1 && ($urandom_range(0, 3) == 0)) p1 = 1'b1;
            data0 = N'($urandom);
            data1 = N'($urandom);
            tick();
        end
        idle_cycles(N + 3);
        check_int("drain_empty", sbq.size(), 0);

        // Wide instance: 8'h81 from requester 1.
        w8 = 8'h81;
        data1_b = w8;
        req1_b = 1'b1;
        #1;
        check_bit("b_ready1", ready1_b, 1'b1);
        check_bit("b_ready0", ready0_b, 1'b0);
        @(negedge clk);
        req1_b = 1'b0;
        data1_b = '0;
        for (int k = 0; k < NB; k++) begin
            check_bit("b_valid", serial_valid_b, 1'b1);
            check_bit("b_bit", serial_out_b, w8[k]);
            check_bit("b_start", frame_start_b, k == 0);
            check_bit("b_end", frame_end_b, k == NB - 1);
            check_bit("b_owner", owner_b, 1'b1);
            @(negedge clk);
        end
        check_bit("b_valid_after", serial_valid_b, 1'b0);
        check_bit("b_busy_after", busy_b, 1'b0);
        req0_b = 1'b1;
        #1;
        check_bit("b_idle_ready0", ready0_b, 1'b1);
        @(negedge clk);
        req0_b = 1'b0;
        repeat (NB + 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
